// File: rtl/btn_pkg.sv
// Shared constants, repeat FSM encoding and width helpers
// for the push-button conditioner.
package btn_pkg;

    localparam int NUM_BTN           = 4;
    localparam int DEBOUNCE_DEF      = 1000000;
    localparam int REPEAT_DELAY_DEF  = 50000000;
    localparam int REPEAT_PERIOD_DEF = 10000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-flop synchronizer, debounce counter, auto-repeat FSM.
// "release" is a reserved word, hence the release_pulse port name.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

    logic          sync1;
    logic          s;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_next;
    rep_state_t    state;
    rep_state_t    state_next;
    logic          flip;
    logic          rise;
    logic          fall;
    logic          rep_fire;

    assign flip = (s != level) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rise = flip && !level;
    assign fall = flip && level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1         <= 1'b0;
            s             <= 1'b0;
            dcnt          <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            state         <= IDLE;
            rcnt          <= '0;
        end else begin
            sync1         <= button;
            s             <= sync1;
            if ((s == level) || flip) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
            if (flip) begin
                level <= ~level;
            end
            press         <= rise | rep_fire;
            release_pulse <= fall;
            state         <= state_next;
            rcnt          <= rcnt_next;
        end
    end

    // A falling level always wins over a due repeat pulse.
    always_comb begin
        state_next = state;
        rcnt_next  = rcnt;
        rep_fire   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise && REPEAT_EN) begin
                    state_next = DELAY;
                    rcnt_next  = '0;
                end
            end
            DELAY: begin
                if (fall) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                end else if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                    state_next = REPEAT;
                    rcnt_next  = '0;
                    rep_fire   = 1'b1;
                end else begin
                    rcnt_next = rcnt + RW'(1);
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                end else if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
                    rcnt_next = '0;
                    rep_fire  = 1'b1;
                end else begin
                    rcnt_next = rcnt + RW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                rcnt_next  = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// Four independent debounced buttons with press/release pulses
// and optional auto-repeat; reset release is synchronized here.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] button,
    output logic [NUM_BTN-1:0] level,
    output logic [NUM_BTN-1:0] press,
    output logic [NUM_BTN-1:0] release_pulse
);

    logic [1:0] rst_pipe;
    logic       rst_sync_n;

    // Asserts immediately, releases two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_pipe[1];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_EN)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_sync_n),
            .button       (button[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench: vector table, timed corner sequences and random traffic
// against a timestamp-based reference model, repeat on and off.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] button = '0;
    logic [3:0] lvl0, prs0, rel0;
    logic [3:0] lvl1, prs1, rel1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .REPEAT_EN(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .button(button),
        .level(lvl0), .press(prs0), .release_pulse(rel0)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .button(button),
        .level(lvl1), .press(prs1), .release_pulse(rel1)
    );

    // Reference model: level flips after D consecutive differing
    // samples; repeats are timestamps A+RD+k*RP from acceptance A.
    logic [3:0] m_q1 = '0, m_s = '0, m_lvl = '0;
    logic [3:0] m_prs0 = '0, m_prs1 = '0, m_rel = '0;
    bit         m_rs1 = 1'b0, m_rs2 = 1'b0;
    int         m_run[4];
    int         m_tacc[4];
    int         m_t = 0;

    task automatic model_reset();
        m_q1 = '0; m_s = '0; m_lvl = '0;
        m_prs0 = '0; m_prs1 = '0; m_rel = '0;
        m_rs1 = 1'b0; m_rs2 = 1'b0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        bit tog;
        int k;
        m_t++;
        m_prs0 = '0; m_prs1 = '0; m_rel = '0;
        if (m_rs2) begin
            for (int i = 0; i < 4; i++) begin
                tog = 1'b0;
                if (m_s[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        tog = 1'b1;
                        m_run[i] = 0;
                        m_lvl[i] = m_s[i];
                        if (m_lvl[i]) begin
                            m_prs0[i] = 1'b1;
                            m_prs1[i] = 1'b1;
                            m_tacc[i] = m_t;
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (!tog && m_lvl[i]) begin
                    k = m_t - m_tacc[i];
                    if (k >= RD && (k - RD) % RP == 0) m_prs1[i] = 1'b1;
                end
            end
            m_s  = m_q1;
            m_q1 = button;
        end
        m_rs2 = m_rs1;
        m_rs1 = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                     name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_level_norep", lvl0, m_lvl);
            check("model_press_norep", prs0, m_prs0);
            check("model_release_norep", rel0, m_rel);
            check("model_level_rep", lvl1, m_lvl);
            check("model_press_rep", prs1, m_prs1);
            check("model_release_rep", rel1, m_rel);
        end
    end

    // kind: 0 press norep, 1 press rep, 2 release rep, 3 release norep
    typedef struct {
        int cyc;
        int kind;
        int ch;
    } ev_t;
    ev_t evq[$];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (prs0[i]) evq.push_back('{cyc, 0, i});
            if (prs1[i]) evq.push_back('{cyc, 1, i});
            if (rel1[i]) evq.push_back('{cyc, 2, i});
            if (rel0[i]) evq.push_back('{cyc, 3, i});
        end
    end

    function automatic int count_ev(input int kind, input int ch,
                                    input int lo, input int hi);
        int n = 0;
        foreach (evq[j]) begin
            if (evq[j].kind == kind && (ch < 0 || evq[j].ch == ch) &&
                evq[j].cyc >= lo && evq[j].cyc <= hi) n++;
        end
        return n;
    endfunction

    function automatic int first_ev(input int kind, input int ch,
                                    input int lo);
        foreach (evq[j]) begin
            if (evq[j].kind == kind && evq[j].ch == ch &&
                evq[j].cyc >= lo) return evq[j].cyc;
        end
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [3:0] btn;
        int         hold;
        logic [3:0] exp_lvl;
        int         exp_prs;
        int         exp_rel;
    } vec_t;
    vec_t vt[10];

    int t0, t1, tr, a, pct;

    initial begin
        vt[0] = '{4'b0000, 10, 4'b0000, 0, 0};
        vt[1] = '{4'b0101, 10, 4'b0101, 2, 0};
        vt[2] = '{4'b0111,  2, 4'b0101, 0, 0};
        vt[3] = '{4'b0101,  8, 4'b0101, 0, 0};
        vt[4] = '{4'b1010, 10, 4'b1010, 2, 2};
        vt[5] = '{4'b0000,  3, 4'b1010, 0, 0};
        vt[6] = '{4'b1010,  8, 4'b1010, 0, 0};
        vt[7] = '{4'b0000, 10, 4'b0000, 0, 2};
        vt[8] = '{4'b1000,  4, 4'b0000, 0, 0};
        vt[9] = '{4'b0000, 12, 4'b0000, 1, 1};

        tick(2);
        chk_on = 1'b1;
        check("reset_level", lvl1, 4'b0000);
        check("reset_press", prs1, 4'b0000);
        check("reset_release", rel1, 4'b0000);
        rst_n = 1'b1;
        tick(4);

        for (int r = 0; r < 10; r++) begin
            t0 = cyc;
            button = vt[r].btn;
            tick(vt[r].hold);
            check("tbl_level", lvl0, vt[r].exp_lvl);
            check("tbl_presses", count_ev(0, -1, t0 + 1, cyc),
                  vt[r].exp_prs);
            check("tbl_releases", count_ev(3, -1, t0 + 1, cyc),
                  vt[r].exp_rel);
        end
        tick(4);

        // single press, no repeat
        t0 = cyc;
        button = 4'b0001;
        tick(5);
        check("s1_level_early", lvl0[0], 1'b0);
        tick(1);
        check("s1_level_edge6", lvl0[0], 1'b1);
        tick(14);
        check("s1_press_time", first_ev(0, 0, t0 + 1), t0 + 6);
        check("s1_press_count", count_ev(0, -1, t0 + 1, cyc), 1);
        check("s1_no_release", count_ev(3, -1, t0 + 1, cyc), 0);
        button = 4'b0000;
        tick(12);

        // 3-cycle glitch is rejected
        t0 = cyc;
        button = 4'b0010;
        tick(3);
        button = 4'b0000;
        tick(12);
        check("s2_no_press", count_ev(1, 1, t0 + 1, cyc), 0);
        check("s2_no_release", count_ev(2, 1, t0 + 1, cyc), 0);
        check("s2_level", lvl1, 4'b0000);

        // held press with auto-repeat
        t0 = cyc;
        a = t0 + 6;
        button = 4'b0100;
        tick(30);
        button = 4'b0000;
        tick(12);
        check("s3_first_press", first_ev(1, 2, t0 + 1), a);
        check("s3_delay_gap", count_ev(1, 2, a + 1, a + 9), 0);
        check("s3_rep_a10", count_ev(1, 2, a + 10, a + 10), 1);
        check("s3_rep_a13", count_ev(1, 2, a + 13, a + 13), 1);
        check("s3_rep_a16", count_ev(1, 2, a + 16, a + 16), 1);
        check("s3_press_total", count_ev(1, 2, t0 + 1, cyc), 8);
        check("s3_release_time", first_ev(2, 2, t0 + 1), t0 + 36);
        check("s3_release_count", count_ev(2, 2, t0 + 1, cyc), 1);
        check("s3_none_after", count_ev(1, 2, t0 + 36, cyc), 0);

        // simultaneous channels
        t0 = cyc;
        button = 4'b1001;
        tick(8);
        check("s4_press_ch0", count_ev(0, 0, t0 + 6, t0 + 6), 1);
        check("s4_press_ch3", count_ev(0, 3, t0 + 6, t0 + 6), 1);
        button = 4'b0000;
        tick(12);

        // reset mid-debounce, bit0 already accepted
        button = 4'b0001;
        tick(8);
        t0 = cyc;
        button = 4'b0011;
        tick(5);
        rst_n = 1'b0;
        #1;
        check("s5_async_level", lvl0, 4'b0000);
        tick(1);
        check("s5_rst_level", lvl0, 4'b0000);
        check("s5_rst_press", prs0, 4'b0000);
        tick(1);
        check("s5_rst_release", rel0, 4'b0000);
        rst_n = 1'b1;
        tr = cyc;
        tick(10);
        check("s5_no_early", count_ev(0, 1, t0 + 1, tr + 7), 0);
        check("s5_press_time", first_ev(0, 1, t0 + 1), tr + 8);
        check("s5_no_release", count_ev(3, -1, t0 + 1, cyc), 0);
        button = 4'b0000;
        tick(12);

        // chatter then stable
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            button[3] = (k % 2 == 0);
            tick(1);
        end
        button = 4'b1000;
        t1 = cyc;
        tick(12);
        check("s6_one_press", count_ev(0, 3, t0 + 1, cyc), 1);
        check("s6_press_time", first_ev(0, 3, t0 + 1), t1 + 6);
        button = 4'b0000;
        tick(12);

        // random traffic, varying toggle density
        for (int seg = 0; seg < 8; seg++) begin
            case ($urandom_range(0, 2))
                0: pct = 2;
                1: pct = 6;
                default: pct = 30;
            endcase
            for (int c = 0; c < 500; c++) begin
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, 99) < pct) button[b] = ~button[b];
                end
                if ($urandom_range(0, 999) == 0) begin
                    rst_n = 1'b0;
                    tick(1 + $urandom_range(0, 2));
                    rst_n = 1'b1;
                end
                tick(1);
            end
        end
        button = 4'b0000;
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
